// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle BCD arithmetic unit.
// Converts BCD operands to binary, does add/sub/mul/div, then converts back.
module alu_sequencer #(
    parameter int SAT_VALUE = 999,
    parameter int ITER      = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        execute,
    input  logic [1:0]  operator,
    input  logic [11:0] a_bcd,
    input  logic [11:0] b_bcd,
    output logic [11:0] result_bcd,
    output logic        busy,
    output logic        done,
    output logic        negative,
    output logic        overflow,
    output logic        div_zero
);

    localparam int W   = ITER;
    localparam int DDW = 12 + W;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CONV,
        DONE
    } state_t;

    state_t         state;
    logic [1:0]     op;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic [2*W-1:0] acc;
    logic [W-1:0]   rem;
    logic [3:0]     cnt;
    logic [DDW-1:0] dd;
    logic           neg_acc;
    logic           ovf_acc;
    logic           dz_acc;

    logic [2*W-1:0] mul_acc;
    logic [W:0]     r_sh;
    logic           ge;
    logic [W-1:0]   rem_nx;
    logic [W-1:0]   quo_nx;
    logic [2*W-1:0] raw;
    logic           ovf_nx;
    logic [W-1:0]   sat_bin;
    logic           calc_last;
    logic           conv_last;
    logic [DDW-1:0] dd_adj;
    logic [DDW-1:0] dd_nx;

    function automatic logic [3:0] clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [W-1:0] bcd_to_bin(input logic [11:0] d);
        logic [W-1:0] h;
        logic [W-1:0] t;
        logic [W-1:0] o;
        h = W'(clamp(d[11:8]));
        t = W'(clamp(d[7:4]));
        o = W'(clamp(d[3:0]));
        return h * W'(100) + t * W'(10) + o;
    endfunction

    // One arithmetic step: shift-add product, restoring-division bit, final result.
    always_comb begin
        mul_acc = acc;
        if (opb[cnt])
            mul_acc = acc + ((2*W)'(opa) << cnt);
        r_sh   = {rem, opa[W-1]};
        ge     = r_sh >= {1'b0, opb};
        rem_nx = ge ? W'(r_sh - {1'b0, opb}) : r_sh[W-1:0];
        quo_nx = {opa[W-2:0], ge};
        raw    = '0;
        case (op)
            OP_ADD: raw = (2*W)'(opa) + (2*W)'(opb);
            OP_SUB: raw = (opa >= opb) ? (2*W)'(opa - opb)
                                       : (2*W)'(opb - opa);
            OP_MUL: raw = mul_acc;
            OP_DIV: raw = (opb == '0) ? '0 : (2*W)'(quo_nx);
            default: raw = '0;
        endcase
        ovf_nx    = raw > (2*W)'(999);
        sat_bin   = ovf_nx ? W'(SAT_VALUE) : raw[W-1:0];
        calc_last = !op[1] || (cnt == 4'(W-1));
        conv_last = cnt == 4'(W-1);
    end

    // Double-dabble step: add 3 to BCD nibbles >= 5, then shift left.
    always_comb begin
        dd_adj = dd;
        for (int i = 0; i < 3; i++) begin
            if (dd[W+4*i +: 4] >= 4'd5)
                dd_adj[W+4*i +: 4] = dd[W+4*i +: 4] + 4'd3;
        end
        dd_nx = {dd_adj[DDW-2:0], 1'b0};
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            op         <= OP_ADD;
            opa        <= '0;
            opb        <= '0;
            acc        <= '0;
            rem        <= '0;
            cnt        <= '0;
            dd         <= '0;
            neg_acc    <= 1'b0;
            ovf_acc    <= 1'b0;
            dz_acc     <= 1'b0;
            result_bcd <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            negative   <= 1'b0;
            overflow   <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (execute) begin
                        op      <= operator;
                        opa     <= bcd_to_bin(a_bcd);
                        opb     <= bcd_to_bin(b_bcd);
                        acc     <= '0;
                        rem     <= '0;
                        cnt     <= '0;
                        neg_acc <= 1'b0;
                        ovf_acc <= 1'b0;
                        dz_acc  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + 4'd1;
                    acc <= mul_acc;
                    rem <= rem_nx;
                    if (op == OP_DIV)
                        opa <= quo_nx;
                    if (calc_last) begin
                        dd      <= DDW'(sat_bin);
                        ovf_acc <= ovf_nx;
                        neg_acc <= (op == OP_SUB) && (opa < opb);
                        dz_acc  <= (op == OP_DIV) && (opb == '0);
                        cnt     <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    dd  <= dd_nx;
                    cnt <= cnt + 4'd1;
                    if (conv_last) begin
                        result_bcd <= dd_nx[W +: 12];
                        negative   <= neg_acc;
                        overflow   <= ovf_acc;
                        div_zero   <= dz_acc;
                        done       <= 1'b1;
                        cnt        <= '0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random checks of alu_sequencer
// against an arithmetic reference model.
module tb_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        execute;
    logic [1:0]  operator;
    logic [11:0] a_bcd;
    logic [11:0] b_bcd;
    logic [11:0] result_bcd;
    logic        busy;
    logic        done;
    logic        negative;
    logic        overflow;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .execute    (execute),
        .operator   (operator),
        .a_bcd      (a_bcd),
        .b_bcd      (b_bcd),
        .result_bcd (result_bcd),
        .busy       (busy),
        .done       (done),
        .negative   (negative),
        .overflow   (overflow),
        .div_zero   (div_zero)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_bin(input logic [11:0] d);
        int h;
        int t;
        int o;
        h = int'(d[11:8]);
        t = int'(d[7:4]);
        o = int'(d[3:0]);
        if (h > 9) h = 9;
        if (t > 9) t = 9;
        if (o > 9) o = 9;
        return h * 100 + t * 10 + o;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model(input logic [1:0] op, input logic [11:0] a,
                         input logic [11:0] b, output logic [11:0] res,
                         output logic n, output logic o, output logic z,
                         output int lat);
        int x;
        int y;
        int r;
        x = clamp_bin(a);
        y = clamp_bin(b);
        n = 1'b0;
        o = 1'b0;
        z = 1'b0;
        r = 0;
        case (op)
            2'd0: r = x + y;
            2'd1: begin
                r = (x >= y) ? x - y : y - x;
                n = x < y;
            end
            2'd2: r = x * y;
            default: begin
                if (y == 0) begin
                    r = 0;
                    z = 1'b1;
                end else begin
                    r = x / y;
                end
            end
        endcase
        if (r > 999) begin
            r = 999;
            o = 1'b1;
        end
        res = to_bcd(r);
        lat = op[1] ? 20 : 11;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [11:0] a,
                          input logic [11:0] b, input bit noisy,
                          input string tag);
        logic [11:0] e_res;
        logic        e_n;
        logic        e_o;
        logic        e_z;
        int          lat;
        int          n;
        model(op, a, b, e_res, e_n, e_o, e_z, lat);
        operator = op;
        a_bcd    = a;
        b_bcd    = b;
        execute  = 1'b1;
        step();
        execute  = 1'b0;
        chk({tag, ":busy_start"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            if (noisy && (n == 2 || n == 14)) begin
                execute  = 1'b1;
                a_bcd    = 12'($urandom);
                b_bcd    = 12'($urandom);
                operator = op ^ 2'b01;
            end else begin
                execute = 1'b0;
            end
            step();
            n++;
        end
        execute = 1'b0;
        chk({tag, ":latency"}, 32'(n), 32'(lat));
        chk({tag, ":result"}, 32'(result_bcd), 32'(e_res));
        chk({tag, ":negative"}, 32'(negative), 32'(e_n));
        chk({tag, ":overflow"}, 32'(overflow), 32'(e_o));
        chk({tag, ":div_zero"}, 32'(div_zero), 32'(e_z));
        chk({tag, ":busy_done"}, 32'(busy), 32'd1);
        step();
        chk({tag, ":done_one"}, 32'(done), 32'd0);
        chk({tag, ":busy_end"}, 32'(busy), 32'd0);
        chk({tag, ":result_hold"}, 32'(result_bcd), 32'(e_res));
    endtask

    function automatic logic [11:0] rnd_bcd();
        logic [11:0] v;
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 7) == 0)
                v[4*i +: 4] = 4'($urandom_range(10, 15));
            else
                v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        bit seen;
        reset    = 1'b1;
        execute  = 1'b0;
        operator = 2'd0;
        a_bcd    = '0;
        b_bcd    = '0;
        step();
        step();
        chk("rst:result", 32'(result_bcd), 32'h000);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:flags", 32'({negative, overflow, div_zero}), 32'd0);

        a_bcd   = 12'h123;
        b_bcd   = 12'h456;
        execute = 1'b1;
        step();
        chk("rst_exec:busy", 32'(busy), 32'd0);
        reset   = 1'b0;
        execute = 1'b0;
        step();
        chk("rst_exec:idle", 32'(busy), 32'd0);

        run_op(2'd0, 12'h123, 12'h456, 1'b0, "add");
        run_op(2'd1, 12'h100, 12'h250, 1'b0, "sub_neg");
        run_op(2'd1, 12'h250, 12'h100, 1'b0, "sub_pos");
        run_op(2'd1, 12'h777, 12'h777, 1'b0, "sub_eq");
        run_op(2'd2, 12'h012, 12'h034, 1'b0, "mul");
        run_op(2'd2, 12'h500, 12'h002, 1'b0, "mul_ovf");
        run_op(2'd2, 12'h999, 12'h999, 1'b0, "mul_max");
        run_op(2'd2, 12'h000, 12'h999, 1'b0, "mul_zero");
        run_op(2'd3, 12'h999, 12'h007, 1'b0, "div");
        run_op(2'd3, 12'h005, 12'h009, 1'b0, "div_small");
        run_op(2'd3, 12'h007, 12'h000, 1'b0, "div_zero");
        run_op(2'd2, 12'h012, 12'h034, 1'b1, "mul_noisy");
        run_op(2'd0, 12'h0F0, 12'h001, 1'b0, "add_clamp");

        operator = 2'd3;
        a_bcd    = 12'h999;
        b_bcd    = 12'h007;
        execute  = 1'b1;
        step();
        execute = 1'b0;
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort:busy", 32'(busy), 32'd0);
        chk("abort:done", 32'(done), 32'd0);
        chk("abort:result", 32'(result_bcd), 32'h000);
        chk("abort:flags", 32'({negative, overflow, div_zero}), 32'd0);
        seen = 1'b0;
        repeat (25) begin
            step();
            if (done) seen = 1'b1;
        end
        chk("abort:no_done", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), rnd_bcd(), rnd_bcd(),
                   1'b0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle arithmetic controller between the operand registers (A, B) and the display mux; the display mux shows its result in place of an operand.
- On each execute strobe from the control FSM it latches both 3-digit BCD operands and the 2-bit operator.
- It converts the operands to binary, runs add/sub in one step, or multiply/divide as 10-step iterative shift-add / restoring division.
- It converts the result back to BCD with a 10-step double-dabble and reports done plus flags.

Parameters:
SAT_VALUE, 999, binary value loaded into the result on overflow; must be <= 999.
ITER, 10, binary operand width and iteration count for mul/div/double-dabble; fixed at 10 for 3-digit operands.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high; also driven by the keypad clear strobe
execute  input  1  one-cycle start strobe from the control FSM
operator  input  2  00 add, 01 sub, 10 mul, 11 div
a_bcd  input  12  operand A, [11:8] hundreds, [7:4] tens, [3:0] ones
b_bcd  input  12  operand B, same layout
result_bcd  output  12  result digits, same layout
busy  output  1  high from the edge after execute is accepted until done inclusive
done  output  1  one-cycle strobe; result and flags are valid and updated
negative  output  1  sub result is B-A because A<B
overflow  output  1  true result > 999; result_bcd = SAT_VALUE in BCD
div_zero  output  1  divide with B=0; result_bcd = 000

Behaviour:
- Reset (synchronous): state IDLE; result_bcd=000; busy=0; done=0; all flags 0; iteration counter 0. Reset mid-operation aborts it with no done pulse; an execute asserted in the same cycle as reset is ignored.
- States: IDLE, CALC, CONV, DONE.
- IDLE: execute=1 at edge 0 latches the operator and both operands, converted to binary (100*hundreds + 10*tens + ones). Any BCD digit > 9 is clamped to 9 first. Next state is CALC; busy=1 from edge 0.
- CALC, add and sub: 1 cycle.
  - Add: sum of A and B.
  - Sub: |A-B|; negative=1 when A<B.
- CALC, mul: 10 cycles, 20-bit shift-add accumulator, one multiplier bit per cycle, LSB first.
- CALC, div: 10 cycles, restoring division, one quotient bit per cycle, MSB first; quotient is truncated and the remainder discarded. B=0 still spends 10 cycles with the result forced to 0 and div_zero=1, so latency stays fixed.
- End of CALC: any binary result > 999 sets overflow and is replaced by SAT_VALUE before CONV.
- CONV: 10 cycles of double-dabble, one bit per cycle, add-3 to each nibble >= 5 before the shift.
- DONE: exactly 1 cycle. done=1; result_bcd and flags updated at the edge entering DONE; busy=1. Next state is IDLE, where busy=0 and done=0.
- Latency: with execute sampled at edge 0, DONE is entered at edge 11 for add/sub and edge 20 for mul/div.
- Between operations: result_bcd and flags hold their last DONE values until the next DONE or reset. Internal flag accumulators clear when execute is accepted.
- execute while busy (CALC/CONV/DONE): ignored, not queued. Operand or operator changes while busy have no effect.
- execute in the IDLE cycle right after DONE is accepted normally, so back-to-back operations are legal.
- Simultaneous flags: only one of negative/overflow/div_zero can be set per operation (sub cannot overflow; div cannot overflow).

Test Plan:
- Reset; add: a=123, b=456, execute at edge 0 -> done only in the cycle after edge 11; result_bcd=579; flags 0; busy high edges 0..11.
- Sub: a=100, b=250 -> result_bcd=150, negative=1. Then a=250, b=100 -> 150, negative=0. Then a=b=777 -> 000, negative=0.
- Mul timing and overflow: 12*34 -> 408 with done after edge 20. 500*2 -> overflow=1, result 999. 999*999 -> overflow=1, result 999. 0*999 -> 000.
- Div: 999/7 -> 142. 5/9 -> 000. 7/0 -> div_zero=1, result 000, done after edge 20 (same latency as nonzero divide).
- Execute ignored while busy: extra execute pulses with changed operands at edges 3 and 15 of a mul -> single done at edge 20 with the original product. Back-to-back: execute in the IDLE cycle after done -> second result correct.
- Reset mid-op: reset at edge 8 of a div -> busy=0, result 000, flags 0 next cycle, no done pulse. Operand digit 0xF is treated as 9: a=0x0F0, b=0x001, add -> 091.
